// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: a 2*WIDTH-bit dividend divided by a WIDTH-bit divisor.
// It produces one quotient bit per enabled clock edge and detects divide-by-zero and overflow when the operands are loaded.
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 enable,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH:0]   r, r_n;
  logic [WIDTH-1:0] q, q_n;
  logic [WIDTH-1:0] d, d_n;
  logic [CW-1:0]    count, count_n;
  logic             busy_n, done_n, dz_n, ov_n;
  logic [WIDTH-1:0] quot_n, rem_n;

  logic [WIDTH-1:0] dvd_hi, dvd_lo;
  logic [WIDTH+1:0] r_shift;
  logic [WIDTH:0]   trial;
  logic             fits;

  assign dvd_hi = dividend[2*WIDTH-1:WIDTH];
  assign dvd_lo = dividend[WIDTH-1:0];

  // Trial subtraction of the divisor from the partial remainder after shifting in the next dividend bit
  always_comb begin
    r_shift = {r, q[WIDTH-1]};
    fits    = (r_shift >= {2'b00, d});
    trial   = r_shift[WIDTH:0] - {1'b0, d};
  end

  always_comb begin
    state_n = state;
    r_n     = r;
    q_n     = q;
    d_n     = d;
    count_n = count;
    busy_n  = busy;
    done_n  = done;
    quot_n  = quotient;
    rem_n   = remainder;
    dz_n    = div_by_zero;
    ov_n    = overflow;

    if (start) begin
      r_n     = {1'b0, dvd_hi};
      q_n     = dvd_lo;
      d_n     = divisor;
      count_n = '0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      quot_n  = '0;
      rem_n   = '0;
      dz_n    = 1'b0;
      ov_n    = 1'b0;
      // Exceptions complete on the load edge itself
      if (divisor == '0) begin
        state_n = DONE;
        done_n  = 1'b1;
        dz_n    = 1'b1;
        quot_n  = '1;
        rem_n   = dvd_lo;
      end else if (dvd_hi >= divisor) begin
        state_n = DONE;
        done_n  = 1'b1;
        ov_n    = 1'b1;
        quot_n  = '1;
        rem_n   = '1;
      end else begin
        state_n = RUN;
        busy_n  = 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          busy_n = 1'b0;
          done_n = 1'b0;
        end
        RUN: begin
          if (enable) begin
            r_n     = fits ? trial : r_shift[WIDTH:0];
            q_n     = {q[WIDTH-2:0], fits};
            count_n = count + 1'b1;
            if (count == LAST) begin
              state_n = DONE;
              busy_n  = 1'b0;
              done_n  = 1'b1;
              quot_n  = q_n;
              rem_n   = r_n[WIDTH-1:0];
              dz_n    = 1'b0;
              ov_n    = 1'b0;
            end
          end
        end
        DONE: begin
          state_n = DONE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r           <= '0;
      q           <= '0;
      d           <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      r           <= r_n;
      q           <= q_n;
      d           <= d_n;
      count       <= count_n;
      busy        <= busy_n;
      done        <= done_n;
      quotient    <= quot_n;
      remainder   <= rem_n;
      div_by_zero <= dz_n;
      overflow    <= ov_n;
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: fixed vectors, stall, abort and reset sequences,
// and random operations checked against an arithmetic reference model.
module tb_restoring_divider;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           enable = 1'b0;
  logic [2*W-1:0] dividend = '0;
  logic [W-1:0]   divisor = '0;
  logic           busy, done, div_by_zero, overflow;
  logic [W-1:0]   quotient, remainder;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic [2*W-1:0] dvd;
    logic [W-1:0]   dvs;
    logic [W-1:0]   expQ;
    logic [W-1:0]   expR;
    logic           expDz;
    logic           expOv;
  } vec_t;

  vec_t vecs[12];

  restoring_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .enable(enable),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Exact integer division; a quotient that cannot fit in W bits is reported as overflow
  task automatic refModel(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                          output logic [W-1:0] eq, output logic [W-1:0] er,
                          output logic edz, output logic eov);
    int qi, ri;
    edz = 1'b0;
    eov = 1'b0;
    if (dvs == '0) begin
      edz = 1'b1;
      eq  = '1;
      er  = dvd[W-1:0];
    end else begin
      qi = int'(dvd) / int'(dvs);
      ri = int'(dvd) % int'(dvs);
      if (qi > (1 << W) - 1) begin
        eov = 1'b1;
        eq  = '1;
        er  = '1;
      end else begin
        eq = W'(qi);
        er = W'(ri);
      end
    end
  endtask

  task automatic checkResult(input string tag, input logic [W-1:0] eq, input logic [W-1:0] er,
                             input logic edz, input logic eov);
    checkOutput({tag, " done"}, done, 1);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " quotient"}, quotient, eq);
    checkOutput({tag, " remainder"}, remainder, er);
    checkOutput({tag, " div_by_zero"}, div_by_zero, edz);
    checkOutput({tag, " overflow"}, overflow, eov);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " done"}, done, 0);
    checkOutput({tag, " quotient"}, quotient, 0);
    checkOutput({tag, " remainder"}, remainder, 0);
    checkOutput({tag, " div_by_zero"}, div_by_zero, 0);
    checkOutput({tag, " overflow"}, overflow, 0);
  endtask

  // Issue one start, then clock until done, optionally stalling and scrambling the operand inputs
  task automatic applyStimulus(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                               input int stallPct, input string tag);
    int enEdges = 0;
    int cyc = 0;
    logic exc;
    exc = (dvs == '0) || ((int'(dvd) / int'(dvs)) > (1 << W) - 1);
    @(negedge clk);
    start = 1'b1; enable = 1'b1; dividend = dvd; divisor = dvs;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (exc) begin
      checkOutput({tag, " exception one-edge done"}, done, 1);
    end else begin
      checkOutput({tag, " busy after start"}, busy, 1);
      checkOutput({tag, " done cleared"}, done, 0);
      while (!done && cyc < 100) begin
        enable   = ($urandom_range(0, 99) >= stallPct);
        dividend = (2*W)'($urandom);
        divisor  = W'($urandom);
        @(posedge clk);
        if (enable) enEdges++;
        @(negedge clk);
        cyc++;
      end
      checkOutput({tag, " enabled edges to done"}, enEdges, W);
    end
    enable = 1'b1;
  endtask

  initial begin
    logic [W-1:0] eq, er;
    logic edz, eov;
    logic [2*W-1:0] rdvd;
    logic [W-1:0] rdvs;

    vecs[0]  = '{16'd45,    8'd3,    8'd15,  8'd0,   1'b0, 1'b0};
    vecs[1]  = '{16'd65025, 8'd255,  8'd255, 8'd0,   1'b0, 1'b0};
    vecs[2]  = '{16'd100,   8'd7,    8'd14,  8'd2,   1'b0, 1'b0};
    vecs[3]  = '{16'h1234,  8'h00,   8'hFF,  8'h34,  1'b1, 1'b0};
    vecs[4]  = '{16'h1234,  8'h10,   8'hFF,  8'hFF,  1'b0, 1'b1};
    vecs[5]  = '{16'd200,   8'd9,    8'd22,  8'd2,   1'b0, 1'b0};
    vecs[6]  = '{16'd0,     8'd1,    8'd0,   8'd0,   1'b0, 1'b0};
    vecs[7]  = '{16'd255,   8'd1,    8'd255, 8'd0,   1'b0, 1'b0};
    vecs[8]  = '{16'hFEFF,  8'hFF,   8'd255, 8'd254, 1'b0, 1'b0};
    vecs[9]  = '{16'h00FF,  8'h10,   8'd15,  8'd15,  1'b0, 1'b0};
    vecs[10] = '{16'h0FFF,  8'h0F,   8'hFF,  8'hFF,  1'b0, 1'b1};
    vecs[11] = '{16'h0EFF,  8'h0F,   8'd255, 8'd14,  1'b0, 1'b0};

    #2;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("idle ignores enable busy", busy, 0);
    checkOutput("idle ignores enable done", done, 0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].dvd, vecs[i].dvs, 0, $sformatf("vec%0d", i));
      checkResult($sformatf("vec%0d", i), vecs[i].expQ, vecs[i].expR, vecs[i].expDz, vecs[i].expOv);
    end

    // 56/8 with a three-cycle stall after the fourth iteration
    @(negedge clk);
    start = 1'b1; enable = 1'b1; dividend = 16'd56; divisor = 8'd8;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("stall%0d busy", s), busy, 1);
      checkOutput($sformatf("stall%0d done", s), done, 0);
    end
    enable = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("stall before 8th edge done", done, 0);
    @(posedge clk);
    @(negedge clk);
    checkResult("stall", 8'd7, 8'd0, 1'b0, 1'b0);

    // Results hold in DONE whatever enable and the operand inputs do
    for (int h = 0; h < 4; h++) begin
      enable = h[0];
      dividend = (2*W)'($urandom);
      divisor = W'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    checkResult("hold", 8'd7, 8'd0, 1'b0, 1'b0);

    // Abort a running 100/7 with a fresh 45/3
    @(negedge clk);
    start = 1'b1; enable = 1'b1; dividend = 16'd100; divisor = 8'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    applyStimulus(16'd45, 8'd3, 0, "abort");
    checkResult("abort", 8'd15, 8'd0, 1'b0, 1'b0);

    // Asynchronous reset from DONE with live flags
    applyStimulus(16'h1234, 8'h00, 0, "predz");
    #2 rst = 1'b1;
    #1 checkAllZero("async reset in done");
    @(negedge clk);
    rst = 1'b0;

    // Reset after the third iteration, then 200/9 from IDLE
    @(negedge clk);
    start = 1'b1; enable = 1'b1; dividend = 16'd100; divisor = 8'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 checkAllZero("reset mid run");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("post reset idle busy", busy, 0);
    checkOutput("post reset idle done", done, 0);
    applyStimulus(16'd200, 8'd9, 0, "after reset");
    checkResult("after reset", 8'd22, 8'd2, 1'b0, 1'b0);

    for (int k = 0; k < 30; k++) begin
      rdvs = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
      rdvd = (2*W)'($urandom_range(0, 65535) >> $urandom_range(0, 8));
      refModel(rdvd, rdvs, eq, er, edz, eov);
      applyStimulus(rdvd, rdvs, 30, $sformatf("rand%0d", k));
      checkResult($sformatf("rand%0d %0d/%0d", k, rdvd, rdvs), eq, er, edz, eov);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width; dividend is 2*WIDTH bits.
REQ-002 Port: clk  input  1  rising-edge clock; sole clock domain.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  latch operands and begin a division; sampled on rising edge.
REQ-005 Port: enable  input  1  advance one iteration per rising edge while running; low = stall.
REQ-006 Port: dividend  input  2*WIDTH  unsigned dividend, sampled when start=1.
REQ-007 Port: divisor  input  WIDTH  unsigned divisor, sampled when start=1.
REQ-008 Port: busy  output  1  high while iterations are in progress.
REQ-009 Port: done  output  1  high when results are valid; held until next start or reset.
REQ-010 Port: quotient  output  WIDTH  registered quotient, valid when done=1.
REQ-011 Port: remainder  output  WIDTH  registered remainder, valid when done=1.
REQ-012 Port: div_by_zero  output  1  exception flag, valid when done=1.
REQ-013 Port: overflow  output  1  quotient-overflow flag, valid when done=1.

Function
REQ-014 FSM states IDLE, RUN, DONE; all state and outputs registered, no combinational outputs.
REQ-015 Any state, start=1 at edge: load R={1'b0,dividend[2W-1:W]}, Q=dividend[W-1:0], D=divisor, count=0; clear done, quotient, remainder, flags; start has priority over enable.
REQ-016 Start with divisor=0: next state DONE in same edge as load; div_by_zero=1, quotient=all ones, remainder=dividend[W-1:0]; enable not required.
REQ-017 Start with divisor!=0 and dividend[2W-1:W] >= divisor: next state DONE; overflow=1, quotient=all ones, remainder=all ones.
REQ-018 Otherwise start enters RUN, busy=1 from that edge.
REQ-019 RUN, enable=1 at edge: shift {R,Q} left 1; T = R_shifted - {1'b0,D} (W+1 bits); if T non-negative R=T, Q[0]=1, else R unchanged, Q[0]=0; count increments.
REQ-020 RUN, enable=0: R, Q, count, state hold unchanged (stall, no limit on length).
REQ-021 On the WIDTH-th enabled iteration edge: quotient=Q, remainder=R[W-1:0], done=1, busy=0, state DONE, flags 0.
REQ-022 Latency: exactly WIDTH enabled edges after the start edge; results visible after that edge.
REQ-023 DONE: outputs held stable regardless of enable; leaves only on start or reset.
REQ-024 IDLE: enable ignored; busy=0, done=0.
REQ-025 Start during RUN aborts current operation and restarts with new operands, no stale result exposed.
REQ-026 Operand inputs are not sampled except at the start edge; changes during RUN have no effect.
REQ-027 Results satisfy dividend = quotient*divisor + remainder, remainder < divisor, for all non-exception inputs.

Reset
REQ-028 rst=1 forces IDLE immediately (asynchronous), independent of clk.
REQ-029 Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, count=0, R=0, Q=0, D=0.
REQ-030 Reset mid-RUN discards the operation; after release, block waits in IDLE for start.

Verification
REQ-031 start, dividend=45, divisor=3, enable=1 for 8 edges -> done=1, quotient=15, remainder=0, flags 0.
REQ-032 dividend=65025, divisor=255 -> quotient=255, remainder=0; dividend=100, divisor=7 -> quotient=14, remainder=2.
REQ-033 dividend=56, divisor=8 with enable low for 3 cycles after iteration 4 -> done only after 8th enabled edge, quotient=7, remainder=0, busy=1 during stall.
REQ-034 divisor=0, dividend=0x1234 -> one edge later done=1, div_by_zero=1, quotient=0xFF, remainder=0x34.
REQ-035 dividend=0x1234, divisor=0x10 -> one edge later done=1, overflow=1, quotient=0xFF, remainder=0xFF.
REQ-036 rst pulse after iteration 3, then start 200/9 -> all outputs 0 during reset; then quotient=22, remainder=2, done=1 after 8 enabled edges.
